// File: rtl/dmem_responder_if.sv
// Load/store request bundle between the mem stage and dmem_responder.
// master = pipeline side, slave = responder side.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [2:0]      mode;
  logic            read_en;
  logic            write_en;
  logic [XLEN-1:0] rdata;
  logic            done;
  logic            stall;
  logic            misalign;

  modport master (
    output addr, wdata, mode,
    output read_en, write_en,
    input  rdata, done, stall, misalign
  );

  modport slave (
    input  addr, wdata, mode,
    input  read_en, write_en,
    output rdata, done, stall, misalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/BUSY/RESP FSM with wait states and lane masking.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of masking.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus_if
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [2:0]      mode_q;
  logic            rd_q, wr_q, done_q, mis_q, mis_d;

  logic [XLEN-1:0] a, wd, word, wlane, ld;
  logic [2:0]      m;
  logic            idle, req, rd, wr, fire;
  logic            is_b, is_h;
  logic [3:0]      be;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [DEPTH_LOG2-1:0] idx;
  logic [XLEN-DEPTH_LOG2-3:0] unused_hi;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign idle = state_q == S_IDLE;
  assign req  = bus_if.read_en | bus_if.write_en;

  // With zero wait states the access runs on the accept edge itself.
  assign a  = idle ? bus_if.addr     : addr_q;
  assign wd = idle ? bus_if.wdata    : wdata_q;
  assign m  = idle ? bus_if.mode     : mode_q;
  assign rd = idle ? bus_if.read_en  : rd_q;
  assign wr = idle ? bus_if.write_en : wr_q;

  assign idx       = a[DEPTH_LOG2+1:2];
  assign unused_hi = a[XLEN-1:DEPTH_LOG2+2];
  assign is_b      = m[1:0] == 2'b00;
  assign is_h      = m[1:0] == 2'b01;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fire = (state_d == S_RESP) && (state_q != S_RESP);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_d = (is_h && a[0])
               || (m == 3'b010 && a[1:0] != 2'b00);
`else
  assign mis_d = 1'b0;
`endif

  always_comb begin
    be    = 4'b1111;
    wlane = wd;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << a[1:0];
        wlane = {4{wd[7:0]}};
      end
      is_h: begin
        be    = a[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  assign word = mem[idx];
  assign bsel = word[{a[1:0], 3'b000} +: 8];
  assign hsel = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (m)
      3'b000:  ld = {{24{bsel[7]}}, bsel};
      3'b001:  ld = {{16{hsel[15]}}, hsel};
      3'b100:  ld = {24'd0, bsel};
      3'b101:  ld = {16'd0, hsel};
      default: ld = word;
    endcase
  end

  // A store keeps the previous load result unless a read rode along.
  always_comb begin
    rdata_d = ld;
    if (mis_d)         rdata_d = '0;
    else if (wr && rd) rdata_d = '0;
    else if (wr)       rdata_d = rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        addr_q  <= bus_if.addr;
        wdata_q <= bus_if.wdata;
        mode_q  <= bus_if.mode;
        rd_q    <= bus_if.read_en;
        wr_q    <= bus_if.write_en;
      end
      done_q <= fire;
      mis_q  <= fire & mis_d;
      if (fire) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire && wr && !mis_d && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlane[i*8 +: 8];
      end
    end
  end

  assign bus_if.rdata    = rdata_q;
  assign bus_if.done     = done_q;
  assign bus_if.misalign = mis_q;
  assign bus_if.stall    = (state_q != S_RESP) && (!idle || req);
endmodule

// File: tb/tb_dmem_responder.sv
// Random + directed bench for dmem_responder, WAIT_CYCLES 0 and 3.
// Expected values come from a byte-array memory model.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_t   [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [2:0]  t_mode  [2];
  logic        t_rd    [2];
  logic        t_wr    [2];
  logic [31:0] o_rdata [2];
  logic        o_done  [2];
  logic        o_stall [2];
  logic        o_mis   [2];

  dmem_responder_if #(.XLEN(32)) bus0 ();
  dmem_responder_if #(.XLEN(32)) bus1 ();

  assign bus0.addr     = t_addr[0];
  assign bus0.wdata    = t_wdata[0];
  assign bus0.mode     = t_mode[0];
  assign bus0.read_en  = t_rd[0];
  assign bus0.write_en = t_wr[0];
  assign o_rdata[0]    = bus0.rdata;
  assign o_done[0]     = bus0.done;
  assign o_stall[0]    = bus0.stall;
  assign o_mis[0]      = bus0.misalign;

  assign bus1.addr     = t_addr[1];
  assign bus1.wdata    = t_wdata[1];
  assign bus1.mode     = t_mode[1];
  assign bus1.read_en  = t_rd[1];
  assign bus1.write_en = t_wr[1];
  assign o_rdata[1]    = bus1.rdata;
  assign o_done[1]     = bus1.done;
  assign o_stall[1]    = bus1.stall;
  assign o_mis[1]      = bus1.misalign;

  dmem_responder #(
    .XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst_t[0]), .bus_if(bus0.slave)
  );

  dmem_responder #(
    .XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)
  ) u_dut3 (
    .clk(clk), .rst(rst_t[1]), .bus_if(bus1.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int waitc [2] = '{0, 3};

  logic [7:0]  mb      [2][4096];
  logic [31:0] rd_last [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int sz_of(input logic [2:0] m);
    if (m[1:0] == 2'b00) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic op(input int d, input bit rd, input bit wr,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] m, output logic [31:0] got);
    int lat, stc, size, base;
    bit mis;
    logic [31:0] v;
    @(posedge clk); #1;
    chk("done_idle", 32'(o_done[d]), 32'd0);
    t_addr[d]  = a;
    t_wdata[d] = wd;
    t_mode[d]  = m;
    t_rd[d]    = rd;
    t_wr[d]    = wr;
    #1;
    stc = int'(o_stall[d]);
    lat = 0;
    while (o_done[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (o_done[d] !== 1'b1) stc += int'(o_stall[d]);
    end
    chk("latency", 32'(lat), 32'(1 + waitc[d]));
    chk("stall_cnt", 32'(stc), 32'(1 + waitc[d]));
    chk("stall_resp", 32'(o_stall[d]), 32'd0);

    size = sz_of(m);
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (size == 2 && a[0]) || (m == 3'b010 && a[1:0] != 2'b00);
`endif
    base = int'(a[11:0]) / size * size;
    if (!mis && wr)
      for (int i = 0; i < size; i++) mb[d][base+i] = wd[8*i +: 8];
    if (mis || (wr && rd)) begin
      rd_last[d] = '0;
    end else if (rd) begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[d][base+i];
      if ((m == 3'b000 || m == 3'b001) && v[8*size-1])
        v = v | ~((32'd1 << (8*size)) - 32'd1);
      rd_last[d] = v;
    end
    chk("rdata", o_rdata[d], rd_last[d]);
    chk("misalign", 32'(o_mis[d]), 32'(mis));
    got = o_rdata[d];
    t_rd[d] = 1'b0;
    t_wr[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [2:0] mtab [8] = '{3'b000, 3'b001, 3'b010, 3'b100,
                           3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    logic [31:0] g, a, wd;
    int k;
    for (int d = 0; d < 2; d++) begin
      rst_t[d] = 1'b1;
      t_addr[d] = '0; t_wdata[d] = '0; t_mode[d] = '0;
      t_rd[d] = 1'b0; t_wr[d] = 1'b0;
      rd_last[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", o_rdata[d], 32'd0);
      chk("rst_done", 32'(o_done[d]), 32'd0);
      chk("rst_mis", 32'(o_mis[d]), 32'd0);
      chk("rst_stall", 32'(o_stall[d]), 32'd0);
      rst_t[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++) begin
      op(d, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, g);
      op(d, 1, 0, 32'h10, 32'h0, 3'b010, g);
      chk("lw_dead", g, 32'hDEADBEEF);
      op(d, 0, 1, 32'h20, 32'h11223344, 3'b010, g);
      op(d, 0, 1, 32'h21, 32'h00000080, 3'b000, g);
      op(d, 1, 0, 32'h21, 32'h0, 3'b000, g);
      chk("lb", g, 32'hFFFFFF80);
      op(d, 1, 0, 32'h21, 32'h0, 3'b100, g);
      chk("lbu", g, 32'h00000080);
      op(d, 1, 0, 32'h20, 32'h0, 3'b010, g);
      chk("lw_sb", g, 32'h11228044);
      op(d, 0, 1, 32'h30, 32'h0, 3'b010, g);
      op(d, 0, 1, 32'h32, 32'h00008001, 3'b001, g);
      op(d, 1, 0, 32'h32, 32'h0, 3'b001, g);
      chk("lh", g, 32'hFFFF8001);
      op(d, 1, 0, 32'h32, 32'h0, 3'b101, g);
      chk("lhu", g, 32'h00008001);
      op(d, 0, 1, 32'h0, 32'h1234, 3'b010, g);
      op(d, 1, 0, 32'h1000, 32'h0, 3'b010, g);
      chk("wrap", g, 32'h1234);
      op(d, 1, 1, 32'h40, 32'hCAFEF00D, 3'b010, g);
      chk("rw_both", g, 32'h0);
      op(d, 1, 0, 32'h40, 32'h0, 3'b010, g);
      chk("rw_store", g, 32'hCAFEF00D);
      op(d, 1, 0, 32'h13, 32'h0, 3'b010, g);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lw_mis", g, 32'h0);
`else
      chk("lw_mask", g, 32'hDEADBEEF);
`endif
      for (int i = 0; i < 16; i++) begin
        a = ($urandom() & 32'hFFFFF000) | 32'(i * 4);
        op(d, 0, 1, a, $urandom(), 3'b010, g);
      end
      for (int n = 0; n < 150; n++) begin
        a = ($urandom() & 32'hFFFFF000)
          | 32'($urandom_range(0, 15) * 4)
          | 32'($urandom_range(0, 3));
        wd = $urandom();
        k = $urandom_range(0, 9);
        op(d, k < 5 || k == 9, k >= 5,
           a, wd, mtab[$urandom_range(0, 7)], g);
      end
    end

    op(1, 1, 0, 32'h40, 32'h0, 3'b010, g);
    @(posedge clk); #1;
    t_addr[1] = 32'h40; t_wdata[1] = 32'h55555555;
    t_mode[1] = 3'b010; t_wr[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    t_wr[1] = 1'b0;
    rst_t[1] = 1'b1;
    #1;
    chk("mid_rst_rdata", o_rdata[1], 32'd0);
    chk("mid_rst_done", 32'(o_done[1]), 32'd0);
    chk("mid_rst_stall", 32'(o_stall[1]), 32'd0);
    @(posedge clk); #1;
    rst_t[1] = 1'b0;
    rd_last[1] = '0;
    op(1, 1, 0, 32'h40, 32'h0, 3'b010, g);
    chk("mid_rst_mem", g, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
